axil_adder_master: RTL and testbench

AXIL_ADDER_MASTER -- requirements
Module: axil_adder_master

---
 rtl/adder_regs_pkg.sv | 27 ++
 rtl/axil_timeout_wdog.sv | 26 ++
 rtl/axil_adder_master.sv | 160 ++++++++++++++++
 tb/tb_axil_adder_master.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/adder_regs_pkg.sv
// Shared register map, response code, FSM encoding and timeout length for the AXI-Lite adder master.
package adder_regs_pkg;

  localparam logic [7:0] REG_OP_A = 8'h00;
  localparam logic [7:0] REG_OP_B = 8'h04;
  localparam logic [7:0] REG_SUM  = 8'h08;
  localparam logic [7:0] REG_OVF  = 8'h0C;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int TIMEOUT_CYCLES = 256;
  localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_A   = 3'd1,
    ST_WR_B   = 3'd2,
    ST_RD_SUM = 3'd3,
    ST_RD_OVF = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic is_write_state(state_t s);
    return (s == ST_WR_A) || (s == ST_WR_B);
  endfunction

endpackage

// File: rtl/axil_timeout_wdog.sv
// Watchdog: fires when i_wait has been high for TIMEOUT_CYCLES consecutive cycles.
module axil_timeout_wdog
  import adder_regs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_wait) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end else begin
      r_count <= '0;
    end
  end

  // The 256th waiting cycle is the one that sees count == 255.
  assign o_expired = i_wait && (r_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axil_adder_master.sv
// AXI-Lite master that writes two operands to an adder slave and reads back sum and overflow.
// Optional watchdog abort on stalled handshakes: define ADDER_MASTER_TIMEOUT_EN.
module axil_adder_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  import adder_regs_pkg::*;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_ar_done;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_overflow;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_timeout;

  assign w_accept     = (r_state == ST_IDLE) && start;
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign result       = r_result;
  assign overflow     = r_overflow;
  assign err          = r_err;
  assign m1_axi_wstrb = '1;

`ifdef ADDER_MASTER_TIMEOUT_EN
  logic w_wait;

  assign w_wait = (m1_axi_awvalid && !m1_axi_awready) ||
                  (m1_axi_wvalid  && !m1_axi_wready)  ||
                  (m1_axi_bready  && !m1_axi_bvalid)  ||
                  (m1_axi_arvalid && !m1_axi_arready) ||
                  (m1_axi_rready  && !m1_axi_rvalid);

  axil_timeout_wdog u_wdog (
    .clk       (m1_axi_aclk),
    .rst_n     (m1_axi_aresetn),
    .i_wait    (w_wait),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    m1_axi_awvalid = 1'b0;
    m1_axi_wvalid  = 1'b0;
    m1_axi_bready  = 1'b0;
    m1_axi_arvalid = 1'b0;
    m1_axi_rready  = 1'b0;
    m1_axi_awaddr  = '0;
    m1_axi_wdata   = '0;
    m1_axi_araddr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_WR_A;
      end
      ST_WR_A, ST_WR_B: begin
        m1_axi_awaddr  = (r_state == ST_WR_A) ? ADDR_WIDTH'(REG_OP_A) : ADDR_WIDTH'(REG_OP_B);
        m1_axi_wdata   = (r_state == ST_WR_A) ? r_op_a : r_op_b;
        m1_axi_awvalid = !r_aw_done;
        m1_axi_wvalid  = !r_w_done;
        // Response is only accepted once both address and data have been handed over.
        m1_axi_bready  = r_aw_done && r_w_done;
        if (m1_axi_bvalid && m1_axi_bready) begin
          if (m1_axi_bresp != RESP_OKAY) w_state_next = ST_DONE;
          else w_state_next = (r_state == ST_WR_A) ? ST_WR_B : ST_RD_SUM;
        end
      end
      ST_RD_SUM, ST_RD_OVF: begin
        m1_axi_araddr  = (r_state == ST_RD_SUM) ? ADDR_WIDTH'(REG_SUM) : ADDR_WIDTH'(REG_OVF);
        m1_axi_arvalid = !r_ar_done;
        m1_axi_rready  = r_ar_done;
        if (m1_axi_rvalid && m1_axi_rready) begin
          if (m1_axi_rresp != RESP_OKAY) w_state_next = ST_DONE;
          else w_state_next = (r_state == ST_RD_SUM) ? ST_RD_OVF : ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_timeout) w_state_next = ST_DONE;
  end

  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      r_state    <= ST_IDLE;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_ar_done  <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Per-phase handshake flags restart on every state change.
      if (w_state_next != r_state) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_ar_done <= 1'b0;
      end else begin
        if (m1_axi_awvalid && m1_axi_awready) r_aw_done <= 1'b1;
        if (m1_axi_wvalid && m1_axi_wready)   r_w_done  <= 1'b1;
        if (m1_axi_arvalid && m1_axi_arready) r_ar_done <= 1'b1;
      end
      if (w_accept) begin
        r_op_a <= op_a;
        r_op_b <= op_b;
        r_err  <= 1'b0;
      end
      if (is_write_state(r_state) && m1_axi_bvalid && m1_axi_bready &&
          (m1_axi_bresp != RESP_OKAY)) begin
        r_err <= 1'b1;
      end
      if (m1_axi_rvalid && m1_axi_rready) begin
        if (m1_axi_rresp != RESP_OKAY) r_err <= 1'b1;
        else if (r_state == ST_RD_SUM) r_result <= m1_axi_rdata;
        else r_overflow <= m1_axi_rdata[0];
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_adder_master.sv
// Directed bench for axil_adder_master with a small AXI-Lite adder slave; timeout case when ADDER_MASTER_TIMEOUT_EN is defined.
module tb_axil_adder_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done, overflow, err;
  logic [31:0] result;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  axil_adder_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n),
    .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .err(err),
    .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
    .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
    .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
    .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
    .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
  );

  // Slave: operand registers at 0x00/0x04, sum at 0x08, carry at 0x0C.
  int          aw_lat = 0, w_lat = 0;
  bit          ar_stuck = 1'b0, bad_b = 1'b0;
  int          aw_cnt, w_cnt, aw_hs = 0, w_hs = 0, ar_hs = 0;
  bit          got_aw, got_w, r_pend;
  logic [7:0]  aw_q, ar_q;
  logic [31:0] w_q;
  logic [31:0] regs [4];
  logic [32:0] sum33;

  assign awready = (aw_cnt >= aw_lat);
  assign wready  = (w_cnt >= w_lat);
  assign arready = !ar_stuck;
  assign bvalid  = got_aw && got_w;
  assign bresp   = (bad_b && aw_q == 8'h04) ? 2'b10 : 2'b00;
  assign rvalid  = r_pend;
  assign rresp   = 2'b00;
  assign sum33   = {1'b0, regs[0]} + {1'b0, regs[1]};
  assign rdata   = (ar_q == 8'h08) ? sum33[31:0] : {31'd0, sum33[32]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 0; got_w <= 0; r_pend <= 0;
      aw_q <= '0; ar_q <= '0; w_q <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (awvalid) aw_cnt <= awready ? 0 : aw_cnt + 1;
      if (wvalid)  w_cnt  <= wready  ? 0 : w_cnt + 1;
      if (awvalid && awready) begin got_aw <= 1; aw_q <= awaddr; aw_hs <= aw_hs + 1; end
      if (wvalid && wready)   begin got_w <= 1; w_q <= wdata; w_hs <= w_hs + 1; end
      if (bvalid && bready)   begin got_aw <= 0; got_w <= 0; regs[aw_q[3:2]] <= w_q; end
      if (arvalid && arready) begin r_pend <= 1; ar_q <= araddr; ar_hs <= ar_hs + 1; end
      if (rvalid && rready)   r_pend <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int exp_cyc, input string tag);
    int cyc;
    @(negedge clk); start = 1'b1; op_a = a; op_b = b;
    @(negedge clk); start = 1'b0; cyc = 1;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_err_clr"}, err, 0);
    while (!done && cyc < 1000) begin @(negedge clk); cyc++; end
    check({tag, "_latency"}, cyc, exp_cyc);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    $display("[TB] txn %s a=%08h b=%08h result=%08h ovf=%0d err=%0d cycles=%0d",
             tag, a, b, result, overflow, err, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int aw0, w0, ar0, n;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    rst_n = 1'b1;

    // Zero-wait slave, basic sum
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
    run_txn(32'd5, 32'd7, 9, "add5_7");
    check("add5_7_result", result, 12);
    check("add5_7_ovf", overflow, 0);
    check("add5_7_err", err, 0);
    check("add5_7_reg0", regs[0], 5);
    check("add5_7_reg1", regs[1], 7);
    check("add5_7_hs", {aw_hs - aw0, w_hs - w0, ar_hs - ar0}, {32'd2, 32'd2, 32'd2});
    check("wstrb", wstrb, 4'hF);

    // Carry out
    run_txn(32'hFFFF_FFFF, 32'd1, 9, "add_ovf");
    check("add_ovf_result", result, 0);
    check("add_ovf_ovf", overflow, 1);
    check("add_ovf_err", err, 0);

    // W ready three cycles after AW, then the reverse
    aw_lat = 0; w_lat = 3; aw0 = aw_hs; w0 = w_hs;
    run_txn(32'd5, 32'd7, 15, "w_late");
    check("w_late_result", result, 12);
    check("w_late_hs", {aw_hs - aw0, w_hs - w0}, {32'd2, 32'd2});
    aw_lat = 3; w_lat = 0; aw0 = aw_hs; w0 = w_hs;
    run_txn(32'd5, 32'd7, 15, "aw_late");
    check("aw_late_result", result, 12);
    check("aw_late_ovf", overflow, 0);
    check("aw_late_hs", {aw_hs - aw0, w_hs - w0}, {32'd2, 32'd2});
    aw_lat = 0; w_lat = 0;

    // SLVERR on the second write: no reads, result kept
    bad_b = 1'b1; ar0 = ar_hs;
    run_txn(32'd1, 32'd2, 5, "bresp_err");
    check("bresp_err_err", err, 1);
    check("bresp_err_result", result, 12);
    check("bresp_err_no_reads", ar_hs - ar0, 0);
    bad_b = 1'b0;

`ifdef ADDER_MASTER_TIMEOUT_EN
    ar_stuck = 1'b1;
    run_txn(32'd3, 32'd4, 261, "timeout");
    check("timeout_err", err, 1);
    check("timeout_valids", {arvalid, rready}, 0);
    ar_stuck = 1'b0;
`endif

    // Asynchronous reset while arvalid is held
    ar_stuck = 1'b1;
    @(negedge clk); start = 1'b1; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk); start = 1'b0; n = 0;
    while (!arvalid && n < 50) begin @(negedge clk); n++; end
    check("rstmid_arvalid_pre", arvalid, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_arvalid", arvalid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_result", result, 0);
    check("rstmid_araddr", araddr, 0);
    $display("[TB] txn rstmid reset asserted during read address phase");
    @(negedge clk); ar_stuck = 1'b0; rst_n = 1'b1;

    run_txn(32'd5, 32'd7, 9, "after_rst");
    check("after_rst_result", result, 12);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
